// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: FSM states and frame geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // BAUDTICK pulses per bit period unless overridden at instantiation.
    localparam int OVERSAMPLE_DFLT = 16;

    // One start bit, eight data bits, one stop bit.
    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = FRAME_BITS - 2;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous transmit FIFO with registered full/empty and first-word-fall-through read.
// Latency: a write is visible on rd_dat the cycle after it is accepted.
// Backpressure: wr_rdy = !full (registered); writes while full are dropped, never overwrite.
//
// Ports: core_clk/arst (async active-high), wr_dat/wr_vld/wr_rdy (push side),
//        rd_en (pop, ignored when empty), rd_dat (head entry), empty.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             core_clk,
    input  logic             arst,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             wr_vld,
    output logic             wr_rdy,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_dat,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // Extra MSB on each pointer separates full (MSBs differ) from empty (equal).
    logic [AW:0]      wptr, rptr, wptr_nxt, rptr_nxt;
    logic             full;
    logic             wr_en, rd_go;

    // Full status comes only from the register, so a same-cycle pop never
    // opens room for a write that arrives while full.
    assign wr_rdy   = !full;
    assign wr_en    = wr_vld && !full;
    assign rd_go    = rd_en && !empty;
    assign wptr_nxt = wr_en ? wptr + 1'b1 : wptr;
    assign rptr_nxt = rd_go ? rptr + 1'b1 : rptr;
    assign rd_dat   = mem[rptr[AW-1:0]];

    always_ff @(posedge core_clk or posedge arst) begin
        if (arst) begin
            wptr  <= '0;
            rptr  <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            wptr  <= wptr_nxt;
            rptr  <= rptr_nxt;
            empty <= (wptr_nxt == rptr_nxt);
            full  <= (wptr_nxt[AW] != rptr_nxt[AW]) &&
                     (wptr_nxt[AW-1:0] == rptr_nxt[AW-1:0]);
        end
    end

    always_ff @(posedge core_clk) begin
        if (wr_en) begin
            mem[wptr[AW-1:0]] <= wr_dat;
        end
    end

endmodule

// File: rtl/uart_tx_baud.sv
// UART transmitter with programmable baud tick generator, 8N1 framing and a transmit FIFO.
// Latency: frame starts on the first BAUDTICK after a byte is queued; a frame is 10*OVERSAMPLE*BAUDDIV CLKs.
// Backpressure: WR_READY low while the FIFO is full; writes while full are dropped.
//
// Ports: CLK, RESET (async active-high), ENABLE (permit new frames), BAUDDIV (CLKs per tick),
//        WR_DATA/WR_VALID/WR_READY (byte push), TXD (serial out, idle high),
//        BAUDTICK (one-CLK pulse at OVERSAMPLE x baud), BUSY (frame in flight or bytes queued).
module uart_tx_baud
    import uart_tx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int OVERSAMPLE = OVERSAMPLE_DFLT
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ENABLE,
    input  logic [15:0] BAUDDIV,
    input  logic [7:0]  WR_DATA,
    input  logic        WR_VALID,
    output logic        WR_READY,
    output logic        TXD,
    output logic        BAUDTICK,
    output logic        BUSY
);
    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

    logic [15:0] baud_cnt;
    logic        div_ok;
    tx_state_t   state;
    logic [3:0]  tick_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_dat;
    logic [7:0]  fifo_dat;
    logic        fifo_empty;
    logic        pop;
    logic        bit_end;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .core_clk (CLK),
        .arst     (RESET),
        .wr_dat   (WR_DATA),
        .wr_vld   (WR_VALID),
        .wr_rdy   (WR_READY),
        .rd_en    (pop),
        .rd_dat   (fifo_dat),
        .empty    (fifo_empty)
    );

    // Divisors below 2 stall the generator entirely, which also freezes any frame.
    assign div_ok  = (BAUDDIV >= 16'd2);
    assign pop     = BAUDTICK && (state == ST_IDLE) && ENABLE && !fifo_empty;
    assign bit_end = (tick_cnt == TICK_LAST);
    assign BUSY    = (state != ST_IDLE) || !fifo_empty;

    // BAUDDIV is sampled only at reload, so a change never stretches the current period.
    // After reset the counter sits at 0, so the first edge is a plain reload.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            baud_cnt <= '0;
            BAUDTICK <= 1'b0;
        end else if (!div_ok) begin
            baud_cnt <= '0;
            BAUDTICK <= 1'b0;
        end else if (baud_cnt == 16'd0) begin
            baud_cnt <= BAUDDIV - 16'd1;
            BAUDTICK <= 1'b0;
        end else begin
            baud_cnt <= baud_cnt - 16'd1;
            BAUDTICK <= (baud_cnt == 16'd1);
        end
    end

    // Framing FSM, advanced only on BAUDTICK; TXD is registered and always
    // shows the level of the bit currently being timed.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= ST_IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_dat <= '0;
            TXD       <= 1'b1;
        end else if (BAUDTICK) begin
            case (state)
                ST_IDLE: begin
                    TXD <= 1'b1;
                    if (pop) begin
                        shift_dat <= fifo_dat;
                        tick_cnt  <= '0;
                        bit_cnt   <= '0;
                        TXD       <= 1'b0;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        tick_cnt <= '0;
                        TXD      <= shift_dat[0];
                        state    <= ST_DATA;
                    end else begin
                        tick_cnt <= tick_cnt + 4'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        tick_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            TXD   <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            // Next bit is shift_dat[1] because the shift lands on this same edge.
                            shift_dat <= {1'b0, shift_dat[7:1]};
                            bit_cnt   <= bit_cnt + 3'd1;
                            TXD       <= shift_dat[1];
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 4'd1;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        tick_cnt <= '0;
                        TXD      <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        tick_cnt <= tick_cnt + 4'd1;
                    end
                end
                default: begin
                    TXD   <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_baud.sv
// Self-checking bench for uart_tx_baud: a serial-line decoder recovers bytes from TXD
// by mid-bit sampling and the tests compare what it decodes against the bytes the
// bench managed to push, plus direct timing/level checks of TXD, BAUDTICK and flags.
module tb_uart_tx_baud;
    localparam int OS = 16;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        ENABLE;
    logic [15:0] BAUDDIV;
    logic [7:0]  WR_DATA;
    logic        WR_VALID;
    logic        WR_READY;
    logic        TXD;
    logic        BAUDTICK;
    logic        BUSY;

    uart_tx_baud #(
        .FIFO_DEPTH (4),
        .OVERSAMPLE (OS)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .ENABLE   (ENABLE),
        .BAUDDIV  (BAUDDIV),
        .WR_DATA  (WR_DATA),
        .WR_VALID (WR_VALID),
        .WR_READY (WR_READY),
        .TXD      (TXD),
        .BAUDTICK (BAUDTICK),
        .BUSY     (BUSY)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [7:0] mon_q[$];
    logic [7:0] exp_q[$];
    int         mon_div = 4;

    // Line decoder: finds a start bit, samples each bit at its middle, demands a stop bit.
    logic       mon_act  = 1'b0;
    int         mon_cnt  = 0;
    logic [7:0] mon_byte = '0;
    always @(negedge CLK) begin : line_decoder
        int bt, k;
        bt = OS * mon_div;
        if (RESET) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (TXD === 1'b0) begin
                mon_act = 1'b1;
                mon_cnt = 0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt % bt == bt / 2) begin
                k = mon_cnt / bt;
                if (k == 0) begin
                    if (TXD !== 1'b0) mon_act = 1'b0;
                end else if (k <= 8) begin
                    mon_byte[k-1] = TXD;
                end else begin
                    checks++;
                    if (TXD !== 1'b1) begin
                        errors++;
                        $display("FAIL stop_bit got %b want 1", TXD);
                    end else begin
                        mon_q.push_back(mon_byte);
                    end
                    mon_act = 1'b0;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wr_byte(input logic [7:0] b, input int max, output bit ok);
        ok       = 1'b0;
        WR_DATA  = b;
        WR_VALID = 1'b1;
        for (int i = 0; i < max; i++) begin
            if (WR_READY) begin
                ok = 1'b1;
                step(1);
                break;
            end
            step(1);
        end
        WR_VALID = 1'b0;
        if (ok) exp_q.push_back(b);
    endtask

    task automatic wait_txd_low(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (TXD === 1'b0) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    task automatic wait_mon(input int n, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (mon_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    task automatic test_reset();
        int n;
        RESET = 1'b1; ENABLE = 1'b0; BAUDDIV = 16'd4; WR_DATA = '0; WR_VALID = 1'b0;
        step(3);
        checks++; if (TXD !== 1'b1)      begin errors++; $display("FAIL rst_txd got %b want 1", TXD); end
        checks++; if (BAUDTICK !== 1'b0) begin errors++; $display("FAIL rst_tick got %b want 0", BAUDTICK); end
        checks++; if (BUSY !== 1'b0)     begin errors++; $display("FAIL rst_busy got %b want 0", BUSY); end
        checks++; if (WR_READY !== 1'b1) begin errors++; $display("FAIL rst_wr_ready got %b want 1", WR_READY); end
        RESET = 1'b0;
        n = 0;
        while (BAUDTICK !== 1'b1 && n < 20) begin step(1); n++; end
        checks++; if (n != 4) begin errors++; $display("FAIL first_tick_edges got %0d want 4", n); end
        step(1);
        n = 1;
        while (BAUDTICK !== 1'b1 && n < 20) begin step(1); n++; end
        checks++; if (n != 4) begin errors++; $display("FAIL tick_period got %0d want 4", n); end
    endtask

    task automatic test_single_frame();
        bit ok;
        int bad, ticks;
        logic [9:0] fr;
        BAUDDIV = 16'd4; mon_div = 4; ENABLE = 1'b1;
        step(6);
        mon_q.delete(); exp_q.delete();
        wr_byte(8'h55, 10, ok);
        wait_txd_low(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_start got no start bit want start"); end
        fr    = {1'b1, 8'h55, 1'b0};
        ticks = 0;
        for (int k = 0; k < 10; k++) begin
            bad = 0;
            for (int s = 0; s < 4 * OS; s++) begin
                if (TXD !== fr[k]) bad++;
                if (BAUDTICK === 1'b1) ticks++;
                step(1);
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL single_bit%0d got %0d wrong samples want 0 (level %b)", k, bad, fr[k]);
            end
        end
        checks++; if (ticks != 10 * OS) begin errors++; $display("FAIL single_ticks got %0d want %0d", ticks, 10 * OS); end
        checks++; if (TXD !== 1'b1 || BUSY !== 1'b0) begin errors++; $display("FAIL single_end got txd=%b busy=%b want 1/0", TXD, BUSY); end
        wait_mon(1, 50, ok);
        checks++; if (!ok || mon_q[0] !== 8'h55) begin errors++; $display("FAIL single_decode got ok=%0d want 0x55", ok); end
    endtask

    task automatic test_back_to_back();
        bit ok, all_ok;
        logic [7:0] b;
        BAUDDIV = 16'd2; mon_div = 2; ENABLE = 1'b0;
        step(6);
        mon_q.delete(); exp_q.delete();
        all_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b = 8'h41 + 8'(i);
            wr_byte(b, 10, ok);
            all_ok &= ok;
        end
        checks++; if (!all_ok || WR_READY !== 1'b0) begin errors++; $display("FAIL b2b_fill got ok=%0d rdy=%b want 1/0", all_ok, WR_READY); end
        WR_DATA = 8'h45; WR_VALID = 1'b1;
        step(3);
        checks++; if (WR_READY !== 1'b0 || TXD !== 1'b1) begin errors++; $display("FAIL b2b_stall got rdy=%b txd=%b want 0/1", WR_READY, TXD); end
        ENABLE = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (WR_READY === 1'b1) begin ok = 1'b1; break; end
            step(1);
        end
        checks++; if (!ok || TXD !== 1'b0) begin errors++; $display("FAIL b2b_release got ok=%0d txd=%b want 1/0", ok, TXD); end
        step(1);
        WR_VALID = 1'b0;
        exp_q.push_back(8'h45);
        wait_mon(5, 5 * 10 * OS * 2 + 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_count got %0d want 5", mon_q.size()); end
        for (int i = 0; i < 5 && i < mon_q.size(); i++) begin
            b = 8'h41 + 8'(i);
            checks++;
            if (mon_q[i] !== b) begin errors++; $display("FAIL b2b_byte%0d got %h want %h", i, mon_q[i], b); end
        end
        step(40);
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL b2b_busy got %b want 0", BUSY); end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int lows;
        BAUDDIV = 16'd2; mon_div = 2; ENABLE = 1'b0;
        step(6);
        mon_q.delete(); exp_q.delete();
        wr_byte(8'hA5, 10, ok);
        wr_byte(8'h3C, 10, ok);
        ENABLE = 1'b1;
        wait_txd_low(100, ok);
        // Middle of data bit 3 (bit 3 of 0xA5 is 0).
        step(2 * OS * 4 + OS);
        checks++; if (!ok || TXD !== 1'b0) begin errors++; $display("FAIL rmid_bit3 got txd=%b want 0", TXD); end
        #2;
        RESET = 1'b1;
        #1;
        checks++; if (TXD !== 1'b1) begin errors++; $display("FAIL rmid_txd_async got %b want 1", TXD); end
        checks++; if (BUSY !== 1'b0 || WR_READY !== 1'b1) begin errors++; $display("FAIL rmid_flags got busy=%b rdy=%b want 0/1", BUSY, WR_READY); end
        step(2);
        RESET = 1'b0;
        lows = 0;
        for (int i = 0; i < 400; i++) begin
            if (TXD !== 1'b1) lows++;
            step(1);
        end
        checks++; if (lows != 0 || mon_q.size() != 0) begin errors++; $display("FAIL rmid_discard got lows=%0d decoded=%0d want 0/0", lows, mon_q.size()); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", BUSY); end
    endtask

    task automatic test_enable_drop();
        bit ok;
        int lows;
        BAUDDIV = 16'd2; mon_div = 2; ENABLE = 1'b0;
        step(6);
        mon_q.delete(); exp_q.delete();
        wr_byte(8'h0F, 10, ok);
        wr_byte(8'hF0, 10, ok);
        ENABLE = 1'b1;
        wait_txd_low(100, ok);
        step(5);
        ENABLE = 1'b0;
        wait_mon(1, 400, ok);
        checks++; if (!ok || mon_q[0] !== 8'h0F) begin errors++; $display("FAIL en_first got ok=%0d want 0x0F", ok); end
        lows = 0;
        for (int i = 0; i < 700; i++) begin
            if (TXD !== 1'b1) lows++;
            step(1);
        end
        checks++; if (lows != 0 || mon_q.size() != 1) begin errors++; $display("FAIL en_hold got lows=%0d decoded=%0d want 0/1", lows, mon_q.size()); end
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL en_busy got %b want 1", BUSY); end
        ENABLE = 1'b1;
        wait_mon(2, 400, ok);
        checks++; if (!ok || mon_q[1] !== 8'hF0) begin errors++; $display("FAIL en_second got ok=%0d want 0xF0", ok); end
        step(40);
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL en_done_busy got %b want 0", BUSY); end
    endtask

    task automatic test_div_hold();
        bit ok;
        int tks, lows, n;
        ENABLE = 1'b0; BAUDDIV = 16'd1; mon_div = 3;
        step(2);
        mon_q.delete(); exp_q.delete();
        wr_byte(8'h96, 10, ok);
        ENABLE = 1'b1;
        tks = 0; lows = 0;
        for (int i = 0; i < 200; i++) begin
            if (BAUDTICK !== 1'b0) tks++;
            if (TXD !== 1'b1) lows++;
            step(1);
        end
        checks++; if (tks != 0) begin errors++; $display("FAIL div1_ticks got %0d want 0", tks); end
        checks++; if (lows != 0 || BUSY !== 1'b1) begin errors++; $display("FAIL div1_hold got lows=%0d busy=%b want 0/1", lows, BUSY); end
        BAUDDIV = 16'd3;
        n = 0;
        while (BAUDTICK !== 1'b1 && n < 20) begin step(1); n++; end
        checks++; if (n != 3) begin errors++; $display("FAIL div3_first_tick got %0d want 3", n); end
        step(1);
        checks++; if (TXD !== 1'b0) begin errors++; $display("FAIL div3_start got %b want 0", TXD); end
        wait_mon(1, 700, ok);
        checks++; if (!ok || mon_q[0] !== 8'h96) begin errors++; $display("FAIL div3_decode got ok=%0d want 0x96", ok); end
        step(60);
    endtask

    task automatic test_full_pop();
        bit ok, all_ok;
        BAUDDIV = 16'd2; mon_div = 2; ENABLE = 1'b0;
        step(6);
        mon_q.delete(); exp_q.delete();
        all_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_byte(8'($urandom), 10, ok);
            all_ok &= ok;
        end
        checks++; if (!all_ok || WR_READY !== 1'b0) begin errors++; $display("FAIL fp_full got ok=%0d rdy=%b want 1/0", all_ok, WR_READY); end
        ENABLE = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (BAUDTICK === 1'b1) break;
            step(1);
        end
        // The pop lands on this edge; the write offered alongside it must be lost.
        WR_DATA = 8'hEE; WR_VALID = 1'b1;
        step(1);
        WR_VALID = 1'b0;
        checks++; if (WR_READY !== 1'b1 || TXD !== 1'b0) begin errors++; $display("FAIL fp_pop got rdy=%b txd=%b want 1/0", WR_READY, TXD); end
        wr_byte(8'hD1, 10, ok);
        checks++; if (!ok || WR_READY !== 1'b0) begin errors++; $display("FAIL fp_count got ok=%0d rdy=%b want 1/0", ok, WR_READY); end
        wait_mon(5, 5 * 10 * OS * 2 + 200, ok);
        checks++; if (!ok || mon_q.size() != exp_q.size()) begin errors++; $display("FAIL fp_decoded got %0d want %0d", mon_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
            checks++;
            if (mon_q[i] !== exp_q[i]) begin errors++; $display("FAIL fp_byte%0d got %h want %h", i, mon_q[i], exp_q[i]); end
        end
        step(40);
    endtask

    task automatic test_random();
        bit ok;
        int div, nb;
        for (int r = 0; r < 3; r++) begin
            div = $urandom_range(2, 3);
            BAUDDIV = 16'(div); mon_div = div; ENABLE = 1'b1;
            step(8);
            mon_q.delete(); exp_q.delete();
            nb = $urandom_range(3, 5);
            for (int i = 0; i < nb; i++) begin
                wr_byte(8'($urandom), 2000, ok);
                step($urandom_range(0, 30));
            end
            wait_mon(exp_q.size(), (nb + 1) * 10 * OS * div + 200, ok);
            checks++; if (!ok || mon_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd%0d_count got %0d want %0d", r, mon_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
                checks++;
                if (mon_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd%0d_byte%0d got %h want %h", r, i, mon_q[i], exp_q[i]); end
            end
            step(10 * div);
        end
    endtask

    initial begin
        RESET = 1'b1; ENABLE = 1'b0; BAUDDIV = 16'd4; WR_DATA = '0; WR_VALID = 1'b0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_reset_mid_frame();
        test_enable_drop();
        test_div_hold();
        test_full_pop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_baud.md
UART_TX_BAUD -- requirements
Module: uart_tx_baud

Interface
REQ-001 SHALL provide parameter FIFO_DEPTH, default 4, meaning transmit FIFO entries (power of two, at least 2).
REQ-002 SHALL provide parameter OVERSAMPLE, default 16, meaning BAUDTICK pulses per bit period.
REQ-003 SHALL provide port CLK  input  1  single system clock; all state on rising edge.
REQ-004 SHALL provide port RESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port ENABLE  input  1  permits starting new frames.
REQ-006 SHALL provide port BAUDDIV  input  16  CLK cycles per BAUDTICK.
REQ-007 SHALL provide port WR_DATA  input  8  byte to transmit.
REQ-008 SHALL provide port WR_VALID  input  1  write request.
REQ-009 SHALL provide port WR_READY  output  1  FIFO not full; write accepted when WR_VALID and WR_READY are both high.
REQ-010 SHALL provide port TXD  output  1  serial line, idle high; feeds the UART stdout/loopback path.
REQ-011 SHALL provide port BAUDTICK  output  1  one-CLK pulse at OVERSAMPLE x baud rate; consumed by the UART monitor.
REQ-012 SHALL provide port BUSY  output  1  high while a frame is in progress or the FIFO is non-empty.

Function
REQ-013 Baud counter SHALL load BAUDDIV-1, decrement every CLK, and assert BAUDTICK for exactly one cycle on reaching 0, then reload.
REQ-014 If BAUDDIV < 2, the block SHALL hold the counter at 0, keep BAUDTICK low, and start no frame; a frame in progress SHALL freeze with TXD unchanged.
REQ-015 A BAUDDIV change SHALL take effect only at the next reload; the current tick period SHALL be unaffected.
REQ-016 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-017 In IDLE, on a BAUDTICK with ENABLE=1 and FIFO non-empty, the FSM SHALL pop one byte into the shift register and enter START.
REQ-018 TXD SHALL be registered: START drives 0, DATA drives shift[0] (LSB first), STOP drives 1, and IDLE drives 1.
REQ-019 Each of START, STOP and each of the 8 DATA bits SHALL last exactly OVERSAMPLE BAUDTICKs, counted by a 4-bit tick counter.
REQ-020 DATA SHALL use a 3-bit bit counter 0..7 and shift right once per bit; after bit 7 the FSM SHALL enter STOP.
REQ-021 From STOP, after OVERSAMPLE ticks the FSM SHALL enter IDLE; a back-to-back pop SHALL occur at the next qualifying BAUDTICK, giving an inter-frame gap of at most one tick.
REQ-022 One frame SHALL take 10*OVERSAMPLE*BAUDDIV CLK cycles.
REQ-023 Deasserting ENABLE mid-frame SHALL let the current frame complete; no new frame SHALL start.
REQ-024 A write while full SHALL be dropped with no overwrite; WR_READY SHALL be combinational from registered full status.
REQ-025 A simultaneous write and pop SHALL both occur when not full; a pop in the same cycle as a write SHALL NOT make a full FIFO accept that write.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with full and empty distinguished by an extra pointer bit.

Reset
REQ-027 RESET high SHALL asynchronously force: TXD=1, BAUDTICK=0, BUSY=0, WR_READY=1, FSM=IDLE, all counters 0, FIFO empty.
REQ-028 RESET mid-frame SHALL abort the frame with TXD high immediately; queued bytes SHALL be discarded.
REQ-029 Reset release SHALL reload the baud counter on the first CLK edge.

Structure
REQ-030 Package uart_tx_pkg SHALL hold the FSM state enum, the OVERSAMPLE default, and the frame-length constant (10 bits).
REQ-031 FIFO SHALL be a sub-module uart_tx_fifo (synchronous, registered full/empty); baud generator and FSM SHALL reside in uart_tx_baud.
REQ-032 The implementation SHALL use no latches and no gated clocks, and SHALL be synthesizable for FPGA.

Verification
REQ-033 BAUDDIV=4, write 0x55, ENABLE=1 -> TXD: 0 then 1,0,1,0,1,0,1,0 then 1; each bit 64 CLK; BAUDTICK every 4 CLK.
REQ-034 BAUDDIV=2, write 5 bytes 0x41..0x45 back-to-back -> 5th write stalls (WR_READY=0) until 1st pop; all 5 bytes decoded by the UART monitor in order.
REQ-035 Assert RESET during DATA bit 3 of 0xA5 -> TXD=1 asynchronously; BUSY=0; FIFO empty; no partial byte decoded.
REQ-036 ENABLE drops during start bit of 0x0F with 0xF0 queued -> 0x0F completes; TXD stays 1; BUSY=1 until ENABLE returns and 0xF0 is sent.
REQ-037 BAUDDIV=1 with data queued -> no BAUDTICK, TXD=1 held; set BAUDDIV=3 -> transmission starts at the first tick.
REQ-038 Write while full simultaneous with a pop -> write dropped; FIFO count decreases by 1.
